// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit (master) and the memory side (slave).
// Single req/ack transaction; bus_rdata is valid in the same cycle as bus_ack.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack bus transaction per load/store, with lane steering and load extension.
// Optional feature macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise misalign_fault.
module load_store_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_bus_read,
  input  logic              cs_bus_write,
  input  logic [1:0]        cs_mem_width,
  input  logic              cs_load_signed,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              bus_error,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_fault,
`endif
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
  typedef enum logic [1:0] {W_WORD = 2'b00, W_HALF = 2'b01, W_BYTE = 2'b10, W_WORD3 = 2'b11} width_e;

  localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  state_e      state_q;
  width_e      width_q;
  logic        signed_q, is_read_q;
  logic [1:0]  off_q, off_d;
  logic [CW-1:0] cnt_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, wdata_d;
  logic [3:0]  bus_be_q, be_d;
  logic [31:0] load_data_q, shifted, load_fmt;
  logic        load_valid_q, bus_error_q;
  logic        req_any, trap_d;

  assign req_any = cs_bus_read | cs_bus_write;

  // Misaligned half uses addr[1] only and misaligned word uses offset 0 unless trapping is enabled.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    be_d    = 4'b1111;
    off_d   = 2'b00;
    wdata_d = wdata;
    unique case (width_e'(cs_mem_width))
      W_HALF: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        off_d   = {addr[1], 1'b0};
        wdata_d = {2{wdata[15:0]}};
      end
      W_BYTE: begin
        be_d    = 4'b0001 << addr[1:0];
        off_d   = addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap_d = ((width_e'(cs_mem_width) == W_HALF) && addr[0]) ||
                  ((width_e'(cs_mem_width) inside {W_WORD, W_WORD3}) && (addr[1:0] != 2'b00));
  assign misalign_fault = misalign_q;
`else
  assign trap_d = 1'b0;
`endif

  always_comb begin
    shifted  = bus.bus_rdata >> {off_q, 3'b000};
    load_fmt = bus.bus_rdata;
    unique case (width_q)
      W_BYTE:  load_fmt = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      W_HALF:  load_fmt = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: reset is synchronous, so it is just the highest-priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      width_q      <= W_WORD;
      signed_q     <= 1'b0;
      is_read_q    <= 1'b0;
      off_q        <= 2'b00;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse clears below are overridden later in the block.
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: if (req_any) begin
          is_read_q   <= cs_bus_read;
          width_q     <= width_e'(cs_mem_width);
          signed_q    <= cs_load_signed;
          off_q       <= off_d;
          cnt_q       <= '0;
          bus_we_q    <= ~cs_bus_read;
          bus_addr_q  <= {addr[31:2], 2'b00};
          bus_be_q    <= be_d;
          bus_wdata_q <= wdata_d;
          if (trap_d) begin
            state_q <= S_DONE;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b1;
`endif
          end else begin
            bus_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
            if (is_read_q) begin
              load_data_q  <= load_fmt;
              load_valid_q <= 1'b1;
            end
          end else if ((BUS_TIMEOUT != 0) && (cnt_q == CW'(BUS_TIMEOUT - 1))) begin
            bus_req_q   <= 1'b0;
            load_data_q <= '0;
            bus_error_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (BUS_TIMEOUT != 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall         = ((state_q == S_IDLE) && req_any) || (state_q == S_REQ);
  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign bus_error     = bus_error_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against a size/lane model.
// Builds with or without MISALIGN_TRAP_EN.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_bus_read, cs_bus_write, cs_load_signed;
  logic [1:0]  cs_mem_width;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, bus_error;
  logic [31:0] load_data;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .cs_bus_read    (cs_bus_read),
    .cs_bus_write   (cs_bus_write),
    .cs_mem_width   (cs_mem_width),
    .cs_load_signed (cs_load_signed),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .bus_error      (bus_error),
`ifdef MISALIGN_TRAP_EN
    .misalign_fault (misalign_fault),
`endif
    .bus            (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes; code 11 behaves as a word.
  function automatic int size_of(input logic [1:0] w);
    return (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  // Lowest byte lane touched: offset rounded down to the access size.
  function automatic int lane_of(input logic [1:0] w, input logic [31:0] a);
    return (int'(a % 4) / size_of(w)) * size_of(w);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
    return 4'(((1 << size_of(w)) - 1) << lane_of(w, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % size_of(w)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] mask, v;
    int nb;
    nb   = size_of(w);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v    = (rd >> (8 * lane_of(w, a))) & mask;
    if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete access; ack_delay = REQ cycles before ack (-1: never ack).
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [1:0] w,
                           input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input int ack_delay);
    bit trap, done;
    int exp_reqs, stalls, reqs;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (a % size_of(w)) != 0;
`endif
    exp_reqs = trap ? 0 : (ack_delay < 0 ? TO : ack_delay + 1);
    cs_bus_read = rd; cs_bus_write = wr; cs_mem_width = w; cs_load_signed = sgn;
    addr = a; wdata = wd;
    #1;
    check({name, ".stall_idle"}, 32'(stall), 32'd1);
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stall) stalls++;
      tick();
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = $urandom;
      if (bus_if.bus_req) begin
        reqs++;
        check({name, ".bus_we"},    32'(bus_if.bus_we), 32'(!rd));
        check({name, ".bus_addr"},  bus_if.bus_addr, {a[31:2], 2'b00});
        check({name, ".bus_be"},    32'(bus_if.bus_be), 32'(model_be(w, a)));
        if (!rd) check({name, ".bus_wdata"}, bus_if.bus_wdata, model_wdata(w, wd));
        if (ack_delay >= 0 && reqs == ack_delay + 1) begin
          bus_if.bus_ack = 1'b1;
          bus_if.bus_rdata = rword;
        end
      end else begin
        done = 1'b1;
        check({name, ".stall_done"}, 32'(stall), 32'd0);
        check({name, ".load_valid"}, 32'(load_valid), 32'(rd && !trap && ack_delay >= 0));
        check({name, ".bus_error"},  32'(bus_error), 32'(!trap && ack_delay < 0));
        if (!trap && ack_delay < 0) check({name, ".load_data_to"}, load_data, 32'h0);
        else if (rd && !trap) check({name, ".load_data"}, load_data, model_load(w, sgn, a, rword));
`ifdef MISALIGN_TRAP_EN
        check({name, ".misalign_fault"}, 32'(misalign_fault), 32'(trap));
`endif
      end
      #1;
    end
    check({name, ".finished"}, 32'(done), 32'd1);
    check({name, ".req_cycles"}, reqs, exp_reqs);
    check({name, ".stall_cycles"}, stalls, exp_reqs + 1);
    bus_if.bus_ack = 1'b0;
    cs_bus_read = 1'b0; cs_bus_write = 1'b0;
    tick();
    check({name, ".pulse_end"}, {29'd0, load_valid, bus_error, bus_if.bus_req}, 32'd0);
    check({name, ".stall_after"}, 32'(stall), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cs_bus_read = 1'b0; cs_bus_write = 1'b0; cs_mem_width = 2'b00; cs_load_signed = 1'b0;
    addr = '0; wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("reset.ctrl", {28'd0, stall, load_valid, bus_error, bus_if.bus_req}, 32'd0);
    check("reset.bus_we", 32'(bus_if.bus_we), 32'd0);
    check("reset.bus_addr", bus_if.bus_addr, 32'd0);
    check("reset.bus_be", 32'(bus_if.bus_be), 32'd0);
    check("reset.bus_wdata", bus_if.bus_wdata, 32'd0);
    check("reset.load_data", load_data, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("reset.misalign", 32'(misalign_fault), 32'd0);
`endif
    tick();

    do_access("lw_0x104",  1, 0, 2'b00, 0, 32'h104, 32'h0, 32'hDEAD_BEEF, 2);
    do_access("lb_0x203",  1, 0, 2'b10, 1, 32'h203, 32'h0, 32'h80FF_1234, 0);
    do_access("lbu_0x203", 1, 0, 2'b10, 0, 32'h203, 32'h0, 32'h80FF_1234, 1);
    do_access("sh_0x302",  0, 1, 2'b01, 0, 32'h302, 32'h0000_ABCD, 32'h0, 1);
    do_access("lw_timeout", 1, 0, 2'b00, 0, 32'h400, 32'h0, 32'h1234_5678, -1);
    do_access("lh_0x101",  1, 0, 2'b01, 1, 32'h101, 32'h0, 32'h1234_F00D, 0);
    do_access("both_rd",   1, 1, 2'b11, 0, 32'h500, 32'hCAFE_F00D, 32'h0BAD_CAFE, 0);
    do_access("sb_0x601",  0, 1, 2'b10, 0, 32'h601, 32'h1122_3344, 32'h0, 3);

    // Reset while in REQ, with a late ack one cycle later.
    cs_bus_read = 1'b1; cs_mem_width = 2'b00; addr = 32'h700;
    tick();
    check("rst_mid.req_seen", 32'(bus_if.bus_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; cs_bus_read = 1'b0;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_mid.req_low", 32'(bus_if.bus_req), 32'd0);
    check("rst_mid.stall", 32'(stall), 32'd0);
    tick();
    bus_if.bus_ack = 1'b0;
    check("rst_mid.late_ack", {30'd0, load_valid, bus_if.bus_req}, 32'd0);
    check("rst_mid.load_data", load_data, 32'd0);
    tick();

    for (int i = 0; i < 40; i++) begin
      int kind, dly;
      kind = $urandom_range(0, 2);
      dly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      do_access($sformatf("rnd%0d", i), kind != 1, kind != 0, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, dly);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
